// File: rtl/spi_flash_stream_reader_pkg.sv
// Shared definitions for the flash stream reader: spi_top slave register map, status bits,
// FSM and access-kind encodings, and the READ header byte selector.
package spi_flash_stream_reader_pkg;

    localparam logic [11:0] REG_TX     = 12'h008;
    localparam logic [11:0] REG_RX     = 12'h00C;
    localparam logic [11:0] REG_STATUS = 12'h010;
    localparam logic [11:0] REG_CS     = 12'h014;

    localparam int ST_BSY = 0;
    localparam int ST_TFE = 1;
    localparam int ST_TFF = 2;
    localparam int ST_RNE = 3;
    localparam int ST_RF  = 4;

    localparam logic [7:0]  CMD_READ_DEFAULT = 8'h03;
    localparam logic [16:0] HDR_BYTES        = 17'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_LO,
        S_ISSUE,
        S_BUSWAIT,
        S_CS_HI
    } state_e;

    typedef enum logic [2:0] {
        ACC_CS_LO,
        ACC_TX,
        ACC_STATUS,
        ACC_RX,
        ACC_CS_HI
    } acc_e;

    // Byte 0 is the opcode, bytes 1..3 the big-endian address, everything after is filler.
    function automatic logic [7:0] tx_byte(input logic [16:0] idx, input logic [23:0] addr,
                                           input logic [7:0] cmd, input logic [7:0] dummy);
        logic [7:0] b;
        case (idx)
            17'd0:   b = cmd;
            17'd1:   b = addr[23:16];
            17'd2:   b = addr[15:8];
            17'd3:   b = addr[7:0];
            default: b = dummy;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_flash_stream_reader_bus_port.sv
// Single-access register-bus master: captures one request, holds it on the bus until the
// slave acknowledges, then releases bus_valid for at least one cycle.
module spi_flash_stream_reader_bus_port
    import spi_flash_stream_reader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_write,
    output logic [11:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    output logic        bus_valid,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        ack,
    output logic [7:0]  rdata
);

    logic [11:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        valid_q, valid_d;
    logic        unused_rdata_hi;

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        valid_d = valid_q;
        if (valid_q && bus_ready) begin
            valid_d = 1'b0;
        end else if (req && !valid_q) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            wstrb_d = req_write ? 4'h1 : 4'h0;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            valid_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            valid_q <= valid_d;
        end
    end

    assign bus_addr        = addr_q;
    assign bus_wdata       = wdata_q;
    assign bus_wstrb       = wstrb_q;
    assign bus_valid       = valid_q;
    assign ack             = valid_q & bus_ready;
    // Only the low byte of any slave register is meaningful to this master.
    assign rdata           = bus_rdata[7:0];
    assign unused_rdata_hi = ^bus_rdata[31:8];

endmodule

// File: rtl/spi_flash_stream_reader.sv
// Drives spi_top through a serial-flash READ and streams the returned data bytes out on a
// valid/ready port, throttling TX so the 8-deep RX FIFO can never overflow.
module spi_flash_stream_reader
    import spi_flash_stream_reader_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = 4,
    parameter logic [7:0] CMD_READ        = CMD_READ_DEFAULT,
    parameter logic [7:0] DUMMY_TX        = 8'hFF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [23:0] flash_addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [11:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    output logic        bus_valid,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    state_e      state_q, state_d;
    acc_e        acc_q, acc_d;
    logic [23:0] addr_q, addr_d;
    logic [16:0] total_q, total_d;
    logic [16:0] tx_cnt_q, tx_cnt_d;
    logic [16:0] rx_cnt_q, rx_cnt_d;
    logic        rx_pending_q, rx_pending_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        m_valid_q, m_valid_d;
    logic [7:0]  m_data_q, m_data_d;

    logic        req;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_write;
    logic        ack;
    logic [7:0]  rdata;
    logic        slot_free;
    logic [16:0] outstanding;

    assign slot_free   = !m_valid_q || m_ready;
    assign outstanding = tx_cnt_q - rx_cnt_q;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        addr_d       = addr_q;
        total_d      = total_q;
        tx_cnt_d     = tx_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        rx_pending_d = rx_pending_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q && !m_ready;
        req          = 1'b0;
        req_addr     = REG_STATUS;
        req_wdata    = '0;
        req_write    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && len != 16'd0) begin
                    addr_d       = flash_addr;
                    total_d      = {1'b0, len} + HDR_BYTES;
                    tx_cnt_d     = '0;
                    rx_cnt_d     = '0;
                    rx_pending_d = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = S_CS_LO;
                end else if (start) begin
                    done_d = 1'b1;
                end
            end
            S_CS_LO: begin
                req       = 1'b1;
                req_addr  = REG_CS;
                req_write = 1'b1;
                acc_d     = ACC_CS_LO;
                state_d   = S_BUSWAIT;
            end
            S_ISSUE: begin
                // The last data byte must leave the output register before CS is released.
                if (rx_cnt_q == total_q) begin
                    if (!m_valid_q) state_d = S_CS_HI;
                end else if (rx_pending_q && slot_free) begin
                    req      = 1'b1;
                    req_addr = REG_RX;
                    acc_d    = ACC_RX;
                    state_d  = S_BUSWAIT;
                end else if (tx_cnt_q < total_q && outstanding < 17'(MAX_OUTSTANDING)) begin
                    req       = 1'b1;
                    req_addr  = REG_TX;
                    req_wdata = {24'd0, tx_byte(tx_cnt_q, addr_q, CMD_READ, DUMMY_TX)};
                    req_write = 1'b1;
                    acc_d     = ACC_TX;
                    state_d   = S_BUSWAIT;
                end else if (!rx_pending_q) begin
                    req      = 1'b1;
                    req_addr = REG_STATUS;
                    acc_d    = ACC_STATUS;
                    state_d  = S_BUSWAIT;
                end
            end
            S_BUSWAIT: begin
                if (ack) begin
                    state_d = S_ISSUE;
                    case (acc_q)
                        ACC_TX:     tx_cnt_d = tx_cnt_q + 17'd1;
                        ACC_STATUS: rx_pending_d = rdata[ST_RNE];
                        ACC_RX: begin
                            rx_cnt_d     = rx_cnt_q + 17'd1;
                            rx_pending_d = 1'b0;
                            if (rx_cnt_q >= HDR_BYTES) begin
                                m_data_d  = rdata;
                                m_valid_d = 1'b1;
                            end
                            if (rx_cnt_d == total_q && !m_valid_d) state_d = S_CS_HI;
                        end
                        ACC_CS_HI: begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                        default: ;
                    endcase
                end
            end
            S_CS_HI: begin
                req       = 1'b1;
                req_addr  = REG_CS;
                req_wdata = 32'd1;
                req_write = 1'b1;
                acc_d     = ACC_CS_HI;
                state_d   = S_BUSWAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            acc_q        <= ACC_STATUS;
            addr_q       <= '0;
            total_q      <= '0;
            tx_cnt_q     <= '0;
            rx_cnt_q     <= '0;
            rx_pending_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            addr_q       <= addr_d;
            total_q      <= total_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_pending_q <= rx_pending_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

    spi_flash_stream_reader_bus_port u_bus_port (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_write (req_write),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wstrb (bus_wstrb),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata),
        .ack       (ack),
        .rdata     (rdata)
    );

endmodule

// File: tb/tb_spi_flash_stream_reader.sv
// Bench for spi_flash_stream_reader: behavioural spi_top slave with TX/RX FIFOs, a serial
// flash that decodes the READ header from MOSI, and a scoreboard of expected data bytes.
module tb_spi_flash_stream_reader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [23:0] flash_addr;
    logic [15:0] len;
    logic        busy, done, m_valid, bus_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic [11:0] bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;

    always #5 clk = ~clk;

    spi_flash_stream_reader dut (
        .clk(clk), .rstn(rstn), .start(start), .flash_addr(flash_addr), .len(len),
        .busy(busy), .done(done), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        logic [7:0] m;
        m = 8'(a[15:8] * 8'd3);
        return a[7:0] ^ m ^ {a[19:16], a[23:20]} ^ 8'h5A;
    endfunction

    // Slave / flash model state and per-transfer statistics.
    logic [7:0]  tx_q[$], rx_q[$], mosi_log[$], exp_q[$];
    logic        cs_n;
    logic        rne_credit;
    logic [23:0] spi_addr;
    int spi_idx, shift_t, rd_wait;
    int n_tx, n_rx, n_cs_lo, n_cs_hi, n_done, n_valid_cyc, n_busy_cyc, max_out, got;
    int ready_pct = 100;
    int ready_block = 0;
    logic [7:0] mb, eb;
    int outc;

    task automatic clear_stats();
        n_tx = 0; n_rx = 0; n_cs_lo = 0; n_cs_hi = 0; n_done = 0;
        n_valid_cyc = 0; n_busy_cyc = 0; max_out = 0; got = 0;
        mosi_log.delete();
    endtask

    initial begin
        bus_ready = 1'b0; bus_rdata = '0; m_ready = 1'b0;
        cs_n = 1'b1; rne_credit = 1'b0; spi_idx = 0; shift_t = 0; rd_wait = 0; spi_addr = '0;
        clear_stats();
        forever begin
            @(negedge clk);
            if (!rstn) begin
                tx_q.delete(); rx_q.delete();
                cs_n = 1'b1; bus_ready = 1'b0; rd_wait = 0; shift_t = 0; rne_credit = 1'b0;
                m_ready = 1'b0;
            end else begin
                if (bus_valid) n_valid_cyc++;
                if (busy) n_busy_cyc++;
                if (done) n_done++;
                // Consumer: handshake fires at the coming posedge with these stable values.
                if (ready_block > 0) begin
                    ready_block--;
                    m_ready = 1'b0;
                end else begin
                    m_ready = ($urandom_range(99) < ready_pct);
                end
                if (m_valid && m_ready) begin
                    got++;
                    if (exp_q.size() == 0) check("extra_byte", 32'(m_data), 32'hFFFF_FFFF);
                    else begin
                        eb = exp_q.pop_front();
                        check("m_data", 32'(m_data), 32'(eb));
                    end
                end
                // SPI shifter: one byte every 4 cycles, flash answers while CS is low.
                if (shift_t > 0) shift_t--;
                else if (tx_q.size() > 0) begin
                    mb = tx_q.pop_front();
                    shift_t = 3;
                    if (!cs_n) begin
                        mosi_log.push_back(mb);
                        if (spi_idx == 1) spi_addr[23:16] = mb;
                        if (spi_idx == 2) spi_addr[15:8]  = mb;
                        if (spi_idx == 3) spi_addr[7:0]   = mb;
                        check("rx_fifo_room", 32'(rx_q.size() < 8), 32'd1);
                        rx_q.push_back(spi_idx < 4 ? 8'hFF : flash_byte(24'(spi_addr + 24'(spi_idx - 4))));
                        spi_idx++;
                    end
                end
                // Register slave: writes ack after 1 cycle, reads after 2.
                if (bus_ready) begin
                    bus_ready = 1'b0;
                    check("bus_gap", 32'(bus_valid), 32'd0);
                end else if (bus_valid) begin
                    if (bus_wstrb == 4'h1) begin
                        bus_ready = 1'b1;
                        if (bus_addr == 12'h008) begin
                            n_tx++;
                            tx_q.push_back(bus_wdata[7:0]);
                            outc = n_tx - n_rx;
                            if (outc > max_out) max_out = outc;
                            check("outstanding", 32'(outc <= 4), 32'd1);
                        end else if (bus_addr == 12'h014) begin
                            if (!bus_wdata[0]) begin n_cs_lo++; spi_idx = 0; end
                            else n_cs_hi++;
                            cs_n = bus_wdata[0];
                        end else check("wr_addr", 32'(bus_addr), 32'h008);
                    end else if (rd_wait == 0) begin
                        rd_wait = 1;
                    end else begin
                        rd_wait = 0;
                        bus_ready = 1'b1;
                        if (bus_addr == 12'h010) begin
                            bus_rdata = {27'd0, rx_q.size() == 8, rx_q.size() != 0,
                                         tx_q.size() == 8, tx_q.size() == 0,
                                         (shift_t > 0) || (tx_q.size() > 0)};
                            rne_credit = (rx_q.size() != 0);
                        end else if (bus_addr == 12'h00C) begin
                            n_rx++;
                            check("rx_after_rne", 32'(rne_credit), 32'd1);
                            rne_credit = 1'b0;
                            bus_rdata = (rx_q.size() != 0) ? {24'd0, rx_q.pop_front()} : 32'hDEAD;
                        end else check("rd_addr", 32'(bus_addr), 32'h00C);
                    end
                end
            end
        end
    end

    task automatic pulse_start(input logic [23:0] a, input int l);
        flash_addr = a;
        len = 16'(l);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int cyc;
        cyc = 0;
        while (n_done == 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(n_done != 0), 32'd1);
        if (n_done == 0) begin
            rstn = 1'b0;
            repeat (2) @(negedge clk);
            rstn = 1'b1;
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_xfer(input logic [23:0] a, input int l, input int pct, input int block,
                            input int exp_reads, input bit inject);
        clear_stats();
        ready_pct = pct;
        for (int i = 0; i < l; i++) exp_q.push_back(flash_byte(24'(a + 24'(i))));
        ready_block = block;
        pulse_start(a, l);
        if (inject) begin
            repeat (15) @(negedge clk);
            pulse_start(~a, 50);
        end
        wait_done(400 + 60 * l + block);
        check("done_count", 32'(n_done), 32'd1);
        check("bytes_out", 32'(got), 32'(l));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("rx_reads", 32'(n_rx), 32'(exp_reads));
        check("tx_writes", 32'(n_tx), 32'(exp_reads));
        check("cs_lo_hi", 32'({n_cs_lo[7:0], n_cs_hi[7:0]}), 32'h0101);
        check("mosi_cmd", 32'(mosi_log.size() > 0 ? mosi_log[0] : 8'h00), 32'h03);
        check("max_outstanding", 32'(max_out <= 4), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    typedef struct {
        logic [23:0] addr;
        int          len;
        int          ready_pct;
        int          exp_reads;
    } vec_t;
    vec_t vecs[5];
    logic [7:0] mosi_exp[7];

    initial begin
        vecs[0] = '{24'h000000, 1,   100, 5};
        vecs[1] = '{24'hABCDEF, 5,   50,  9};
        vecs[2] = '{24'hFFFFFE, 7,   30,  11};
        vecs[3] = '{24'h100000, 12,  80,  16};
        vecs[4] = '{24'h0000F0, 256, 100, 260};
        mosi_exp = '{8'h03, 8'h01, 8'h23, 8'h45, 8'hFF, 8'hFF, 8'hFF};

        rstn = 1'b0; start = 1'b0; flash_addr = '0; len = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_bus_valid", 32'(bus_valid), 32'd0);
        check("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-length request: done on the next cycle, no bus traffic, never busy.
        clear_stats();
        pulse_start(24'h123456, 0);
        check("len0_done", 32'(done), 32'd1);
        repeat (4) @(negedge clk);
        check("len0_done_count", 32'(n_done), 32'd1);
        check("len0_bus_cycles", 32'(n_valid_cyc), 32'd0);
        check("len0_busy_cycles", 32'(n_busy_cyc), 32'd0);

        // Header/payload on MOSI for a short read.
        run_xfer(24'h012345, 3, 100, 0, 7, 1'b0);
        check("mosi_len", 32'(mosi_log.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            check("mosi_byte", 32'(i < mosi_log.size() ? mosi_log[i] : 8'h00), 32'(mosi_exp[i]));

        for (int v = 0; v < 5; v++)
            run_xfer(vecs[v].addr, vecs[v].len, vecs[v].ready_pct, 0, vecs[v].exp_reads, 1'b0);

        // Long consumer stall: TX throttles at the outstanding limit, data survives in order.
        run_xfer(24'h054321, 16, 100, 500, 20, 1'b0);

        // A second start while busy must not disturb the running transfer.
        run_xfer(24'h00A000, 8, 100, 0, 12, 1'b1);

        // Reset in the middle of a transfer, then a clean transfer.
        clear_stats();
        ready_pct = 100;
        for (int i = 0; i < 40; i++) exp_q.push_back(flash_byte(24'(24'h002000 + 24'(i))));
        pulse_start(24'h002000, 40);
        begin
            int cyc;
            cyc = 0;
            while (got < 10 && cyc < 3000) begin
                @(negedge clk);
                cyc++;
            end
            check("mid_reached_10", 32'(got >= 10), 32'd1);
        end
        rstn = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_bus_valid", 32'(bus_valid), 32'd0);
        check("mid_rst_m_data", 32'(m_data), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        run_xfer(24'h777777, 6, 100, 0, 10, 1'b0);

        for (int r = 0; r < 4; r++) begin
            int l;
            l = $urandom_range(1, 40);
            run_xfer(24'($urandom), l, $urandom_range(20, 100), 0, l + 4, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
